muldiv_seq: RTL

- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Accepts one operation per start pulse, runs a 32-step shift-add or restoring-divide loop, applies sign correction, and returns a registered result with a one-cycle done pulse.
- The core holds the pipeline while busy is high.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide sequencer:
// funct3 op codes, FSM state encoding and the special divide results.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Quotient returned for divide-by-zero, and the most negative integer
    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. One operation per start pulse:
// magnitudes are latched, a 32-step shift-add (multiply) or restoring divide
// runs on a shared XLEN+1 bit adder, then sign correction selects the result.
// Handshake: start is sampled only while busy is low; a sampled start raises
// busy on the same edge, busy stays high until the edge after the one-cycle
// done pulse, and result holds its value until the next done.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    // Architectural state
    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    // Operation context latched at the start edge
    logic [2:0]          op_q;
    logic                neg_q;      // final result must be negated
    logic                early_q;    // special value already sits in acc_q low word
    logic [XLEN-1:0]     mcand_q;    // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q;      // {hi, lo} product or {rem, quot}
    logic [CW-1:0]       count_q;

    // Operand decode
    logic                a_signed;
    logic                b_signed;
    logic                sa;
    logic                sb;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                neg_d;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     early_val;

    // Shared adder and per-step next accumulator
    logic [XLEN:0]       add_a;
    logic [XLEN:0]       add_b;
    logic                add_sub;
    logic [XLEN:0]       add_sum;
    logic [2*XLEN-1:0]   acc_d;

    // Sign-corrected result selection
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     result_d;

    // Decode signedness, magnitudes, result sign and divide early-outs
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        sa    = a_signed & a[XLEN-1];
        sb    = b_signed & b[XLEN-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
        // Remainder takes the dividend's sign; everything else sign(a)^sign(b)
        neg_d = (is_div_op(op) && op[1]) ? sa : (sa ^ sb);

        div_zero  = is_div_op(op) && (b == '0);
        div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == INT_MIN) && (&b);
        early_val = '0;
        if (div_zero) begin
            early_val = op[1] ? a : DIV0_Q;
        end else if (div_ovf) begin
            early_val = op[1] ? '0 : INT_MIN;
        end
    end

    // One shared add/sub: multiply adds into the upper word, divide trial-subtracts
    always_comb begin
        add_b   = {1'b0, mcand_q};
        add_sub = 1'b0;
        add_a   = {1'b0, acc_q[2*XLEN-1:XLEN]};
        if (is_div_op(op_q)) begin
            // Shifted remainder can need XLEN+1 bits, so take it straight from acc_q
            add_a   = acc_q[2*XLEN-1:XLEN-1];
            add_sub = 1'b1;
        end
        add_sum = add_a + (add_b ^ {(XLEN+1){add_sub}}) + {{XLEN{1'b0}}, add_sub};

        if (is_div_op(op_q)) begin
            // add_sum[XLEN] is the borrow: set means the trial went negative
            if (add_sum[XLEN]) begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end else begin
                acc_d = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            if (acc_q[0]) begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end
    end

    // Sign correction and result word selection used on the FIX edge
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        result_d = '0;
        if (early_q) begin
            result_d = acc_q[XLEN-1:0];
        end else begin
            case (op_q)
                OP_MUL:                     result_d = prod_fix[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:            result_d = quot_fix;
                default:                    result_d = rem_fix;
            endcase
        end
    end

    // Sequencer FSM with registered busy/done/result and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            early_q  <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        neg_q   <= neg_d;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        mcand_q <= mag_b;
                        if (div_zero || div_ovf) begin
                            early_q <= 1'b1;
                            acc_q   <= {{XLEN{1'b0}}, early_val};
                            state_q <= S_FIX;
                        end else begin
                            // Low word is the multiplier or the dividend
                            early_q <= 1'b0;
                            acc_q   <= {{XLEN{1'b0}}, mag_a};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(XLEN - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
